// File: rtl/sls_mux_scan_ctrl_v.sv
// sls_mux_scan_ctrl_v
//   Scan controller for an n-bit 4:1 mux. It drives the mux select lines,
//   waits SETTLE cycles, captures the mux output into a holding register and
//   offers it downstream with a valid/ready handshake. Channels d0..d3 are
//   visited in order, one frame per start pulse, or back-to-back frames
//   while continuous is high.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   begin a frame (only honoured in IDLE)
//   continuous  in   restart at channel 0 after channel 3 (sampled at that handshake)
//   f_in        in   mux output f
//   s1, s0      out  mux select (registered channel index)
//   out_data    out  captured mux word
//   out_chan    out  channel index of out_data
//   out_valid   out  out_data/out_chan valid
//   out_ready   in   downstream accept
//   busy        out  frame in progress
//   frame_done  out  one-cycle pulse after the channel-3 word is accepted
module sls_mux_scan_ctrl_v #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [WIDTH-1:0] f_in,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  // The counter is loaded with SETTLE-1 so that f_in is sampled exactly
  // SETTLE edges after the select lines change.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       ochan_q, ochan_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      chan_q  <= 2'd0;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      ochan_q <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ochan_q <= ochan_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ochan_d = ochan_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          chan_d  = 2'd0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = f_in;
          ochan_d = chan_q;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        // valid_q is always set in HOLD, so out_ready alone marks the handshake.
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = CNT_INIT;
          if (chan_q != 2'd3) begin
            chan_d  = chan_q + 2'd1;
            state_d = S_SETTLE;
          end else begin
            done_d = 1'b1;
            chan_d = 2'd0;
            if (continuous) begin
              state_d = S_SETTLE;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        chan_d  = 2'd0;
      end
    endcase
  end

  // Select lines come straight from the channel register, so they stay
  // stable through HOLD and drop to 00 whenever chan returns to 0.
  assign s1         = chan_q[1];
  assign s0         = chan_q[0];
  assign out_data   = data_q;
  assign out_chan   = ochan_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sls_mux_scan_ctrl_v.sv
module tb_sls_mux_scan_ctrl_v;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       continuous;
  logic [7:0] f_in;
  logic       s1, s0;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_data [4];

  always #5 clk = ~clk;

  // 8-bit 4:1 mux: d0=AA, d1=55, d2=FF, d3=00
  always_comb begin
    case ({s1, s0})
      2'd0:    f_in = 8'hAA;
      2'd1:    f_in = 8'h55;
      2'd2:    f_in = 8'hFF;
      default: f_in = 8'h00;
    endcase
  end

  sls_mux_scan_ctrl_v #(.WIDTH(8), .SETTLE(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .f_in       (f_in),
    .s1         (s1),
    .s0         (s0),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sel"}, {s1, s0}, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_chan"}, out_chan, 0);
    chk({tag, "_done"}, frame_done, 0);
  endtask

  // Checks edges 1..12 of a frame whose start edge (edge 0) has just passed,
  // with out_ready held high. Optionally clears continuous or pulses start
  // after the check at a given relative edge.
  task automatic check_frame(input string tag, input bit end_busy,
                             input int clr_at, input int pulse_at);
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk({tag, "_valid"}, out_valid, (e % 3 == 2));
      if (e % 3 == 2) begin
        chk({tag, "_data"}, out_data, exp_data[e / 3]);
        chk({tag, "_chan"}, out_chan, e / 3);
        chk({tag, "_sel"}, {s1, s0}, e / 3);
      end
      chk({tag, "_done"}, frame_done, (e == 12));
      if (e == 12) begin
        chk({tag, "_busy_end"}, busy, end_busy);
        chk({tag, "_sel_end"}, {s1, s0}, 0);
      end else begin
        chk({tag, "_busy"}, busy, 1);
      end
      if (e == clr_at) continuous = 1'b0;
      start = (e == pulse_at);
    end
  endtask

  initial begin
    exp_data[0] = 8'hAA;
    exp_data[1] = 8'h55;
    exp_data[2] = 8'hFF;
    exp_data[3] = 8'h00;
    reset      = 1'b1;
    start      = 1'b1;
    continuous = 1'b0;
    out_ready  = 1'b0;

    // Reset held two cycles with start high
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk_idle("idle_after_reset");

    // Single frame, out_ready high
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("single_busy0", busy, 1);
    chk("single_valid0", out_valid, 0);
    check_frame("single", 1'b0, -1, -1);
    tick();
    chk("single_done_clear", frame_done, 0);
    chk("single_idle_valid", out_valid, 0);

    // Backpressure on channel 1
    start = 1'b1;
    tick();                      // edge 0
    start = 1'b0;
    tick();                      // edge 1
    tick();                      // edge 2: ch0 valid
    chk("bp_ch0", out_data, 8'hAA);
    tick();                      // edge 3: ch0 accepted
    out_ready = 1'b0;
    tick();                      // edge 4
    tick();                      // edge 5: ch1 valid
    chk("bp_ch1_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h55);
      chk("bp_hold_chan", out_chan, 1);
      chk("bp_hold_sel", {s1, s0}, 1);
    end
    out_ready = 1'b1;
    tick();                      // single acceptance
    chk("bp_accept_valid", out_valid, 0);
    chk("bp_accept_sel", {s1, s0}, 2);
    tick();
    chk("bp_gap_valid", out_valid, 0);
    tick();
    chk("bp_ch2_valid", out_valid, 1);
    chk("bp_ch2_data", out_data, 8'hFF);
    chk("bp_ch2_chan", out_chan, 2);
    tick();
    tick();
    tick();
    chk("bp_ch3_data", out_data, 8'h00);
    chk("bp_ch3_chan", out_chan, 3);
    tick();
    chk("bp_done", frame_done, 1);
    chk("bp_busy_end", busy, 0);
    tick();

    // Continuous: two back-to-back frames, continuous cleared mid-second
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame("cont1", 1'b1, -1, -1);
    check_frame("cont2", 1'b0, 4, -1);
    tick();
    chk("cont_idle_valid", out_valid, 0);
    chk("cont_idle_busy", busy, 0);
    chk("cont_idle_done", frame_done, 0);
    tick();
    chk("cont_stays_idle", out_valid, 0);

    // Reset while holding channel 2
    start = 1'b1;
    tick();                      // edge 0
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();   // edge 8: ch2 valid
    chk("rst_pre_data", out_data, 8'hFF);
    out_ready = 1'b0;
    tick();
    chk("rst_pre_hold", out_valid, 1);
    reset = 1'b1;
    tick();
    chk_idle("rst_mid");
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame("after_rst", 1'b0, -1, -1);
    tick();

    // start pulsed while channel 1 is settling
    start = 1'b1;
    tick();
    start = 1'b0;
    check_frame("busy_start", 1'b0, -1, 4);
    tick();
    chk("busy_start_idle", busy, 0);
    chk("busy_start_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
